ir_key_queue: RTL
=================

Name: ir_key_queue

Overview:
- Downstream consumer of the IR NEC decoder. Captures each validated 8-bit key code, qualified by the decoder's one-cycle `done` pulse, into a small first-word-fall-through queue.
- Presents queued codes to application logic (display/command stage) through a valid/ready handshake, so no key is lost while the consumer is busy.
- Provides occupancy and overflow status.
- Clock domain: the decoder's 50 MHz clock (20 ns period).

Parameters:
- DEPTH, 4: queue entries; must be a power of 2, ≥ 2.
- HOLDOFF_CYCLES, 12500000: duplicate-suppression window, 250 ms at 50 MHz. Only used when IR_KEY_DEDUP_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- key_in  input  8  key code from the decoder; valid only when key_done=1.
- key_done  input  1  one-cycle strobe from the decoder; key_in is valid this cycle.
- out_key  output  8  head-of-queue key code.
- out_valid  output  1  queue non-empty; out_key is valid.
- out_ready  input  1  consumer accepts out_key this cycle.
- level  output  $clog2(DEPTH)+1  current number of stored entries.
- overflow  output  1  sticky; set when a key is dropped because the queue is full.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Pointers and level become 0; out_valid=0, out_key=8'h00, overflow=0.
  - Dedup state returns to IDLE.
  - Reset mid-operation discards all entries; a key_done in the same cycle as rst is ignored.
- Storage:
  - Circular buffer, write and read pointers each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - level is held as a separate counter, 0..DEPTH.
- Push:
  - push_req = key_done, further qualified by dedup when the optional feature is enabled.
  - Accepted if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
  - An accepted push writes key_in at the write pointer and increments it.
- Pop:
  - pop = out_valid & out_ready. Advances the read pointer.
  - out_ready while out_valid=0 has no effect.
- Level update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged.
- Output behaviour (first-word fall-through):
  - out_key is driven from the head entry.
  - out_valid = (level≠0).
  - When empty, out_key holds its last value (8'h00 after reset).
  - Latency: key_done at edge N gives out_valid=1 and out_key=key_in after edge N.
- Full: a push request that is not accepted drops key_in and sets overflow=1. overflow clears only on rst.
- Handshake rule: once out_valid=1, out_key stays stable until it is popped.

Optional Feature:
- Macro: IR_KEY_DEDUP_EN.
- Defined: adds a dedup FSM with states IDLE and HOLD, plus a last_key register and a hold counter of width $clog2(HOLDOFF_CYCLES+1).
  - IDLE: key_done → push_req=1, last_key=key_in, counter=0, go to HOLD.
  - HOLD:
    - Counter increments each cycle.
    - key_done with key_in==last_key → suppressed (no push, overflow not set); counter restarts at 0.
    - key_done with key_in≠last_key → push_req=1; last_key and counter updated; stays in HOLD.
    - Counter reaching HOLDOFF_CYCLES−1 with no key_done → IDLE.
- Not defined: every key_done is a push_req; no FSM, no counter.

Decomposition:
- Package ir_pkg:
  - KEY_W=8.
  - CLK_HZ=50_000_000.
  - dedup state typedef {IDLE, HOLD}.
  - Helper constant for ms-to-cycles conversion.
- Sub-module ir_sync_fifo: generic FWFT FIFO (WIDTH, DEPTH). Provides push, pop, full, empty and level; same clk/rst.
- ir_key_queue contains the accept/overflow logic and the optional dedup FSM.

Test Plan:
- Reset, then key_done with key_in=8'h45 while out_ready=0 → after next edge out_valid=1, out_key=8'h45, level=1, overflow=0.
- Five keys 8'h01..8'h05 with out_ready=0, DEPTH=4 → level=4, fifth dropped, overflow=1. Then out_ready=1 yields 01,02,03,04 on consecutive cycles, then out_valid=0.
- Full queue, key_done=8'h09 and out_ready=1 in the same cycle → 8'h01 popped, 8'h09 accepted, level remains 4, overflow unchanged.
- out_valid=1 with out_ready=0 for 100 cycles → out_key stable. Assert rst mid-stream → level=0, out_valid=0, overflow=0 next cycle.
- IR_KEY_DEDUP_EN, HOLDOFF_CYCLES=100:
  - key 8'h18 at t=0 → queued.
  - 8'h18 at t=50 → suppressed; window restarts.
  - 8'h18 at t=140 → suppressed.
  - 8'h52 at t=150 → queued.
  - 8'h52 at t=260 → queued (IDLE again).
  - Final level=3.
- IR_KEY_DEDUP_EN not defined: same stimulus → all five keys queued; with DEPTH=4 the fifth sets overflow=1.

Source files
------------

// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared constants and types for the IR key path
// Key width, system clock rate and the dedup state encoding.
package ir_pkg;

  localparam int KEY_W         = 8;
  localparam int CLK_HZ        = 50_000_000;
  localparam int CYCLES_PER_MS = CLK_HZ / 1000;

  typedef enum logic {
    IDLE,
    HOLD
  } dedup_state_t;

  function automatic int ms_to_cycles(input int ms);
    return ms * CYCLES_PER_MS;
  endfunction

endpackage

// File: rtl/ir_sync_fifo.sv
// rtl/ir_sync_fifo.sv - first-word-fall-through FIFO with level counter
// When empty, dout keeps the most recently popped word (zero after reset).
module ir_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LEVEL);
  assign level = level_q;
  assign dout  = empty ? hold_q : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    // A full queue still takes a word when the head leaves in the same cycle.
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    hold_d   = hold_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      hold_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      level_d = level_q + LW'(1);
    end else if (!do_push && do_pop) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/ir_key_queue.sv
// rtl/ir_key_queue.sv - queues decoded IR key codes behind a valid/ready port
// Optional repeat-key suppression is enabled by defining IR_KEY_DEDUP_EN.
module ir_key_queue
  import ir_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int HOLDOFF_CYCLES = ms_to_cycles(250)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEY_W-1:0]       key_in,
  input  logic                   key_done,
  output logic [KEY_W-1:0]       out_key,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  logic push_req;
  logic fifo_full, fifo_empty;
  logic overflow_q, overflow_d;

`ifdef IR_KEY_DEDUP_EN
  localparam int CW = $clog2(HOLDOFF_CYCLES + 1);

  dedup_state_t     state_q, state_d;
  logic [KEY_W-1:0] last_key_q, last_key_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    push_req   = 1'b0;
    state_d    = state_q;
    last_key_d = last_key_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (key_done) begin
          push_req   = 1'b1;
          last_key_d = key_in;
          cnt_d      = '0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + CW'(1);
        if (key_done) begin
          // Any key, repeated or not, restarts the hold window.
          cnt_d = '0;
          if (key_in != last_key_q) begin
            push_req   = 1'b1;
            last_key_d = key_in;
          end
        end else if (cnt_q == CW'(HOLDOFF_CYCLES - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_key_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_key_q <= last_key_d;
      cnt_q      <= cnt_d;
    end
  end
`else
  logic unused_holdoff;
  assign unused_holdoff = ^HOLDOFF_CYCLES;
  assign push_req       = key_done;
`endif

  ir_sync_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (key_in),
    .pop   (out_ready),
    .dout  (out_key),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign out_valid = ~fifo_empty;
  assign overflow  = overflow_q;

  // Full implies non-empty, so out_ready alone tells whether the head frees a slot.
  always_comb begin
    overflow_d = overflow_q | (push_req & fifo_full & ~out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

endmodule
